sm_loop_filter: RTL

Parametrised sign-magnitude proportional-integral loop filter for the ADPLL: takes the sign-magnitude phase error from the detector, adds the proportional term to a saturating integrator, and produces a registered sign-magnitude DCO control word. It sits between the phase detector and the DCO control register. It generalises the 5-bit combinational sign-magnitude add/subtract stage to configurable widths, with accumulation, saturation, clearing and a 2-stage valid pipeline.

---
 rtl/sm_pkg.sv | 33 +++
 rtl/sm_sat_add.sv | 32 +++
 rtl/sm_loop_filter.sv | 113 +++++++++++
 3 files changed

// File: rtl/sm_pkg.sv
// sm_pkg: shared helpers for the sign-magnitude loop filter.
//   SM_POS / SM_NEG : sign-bit encodings (1 = negative)
//   max_mag(n)      : 2^n - 1
//   sm_to_tc        : sign-magnitude -> two's complement
//   tc_to_sm        : two's complement -> sign-magnitude (never yields -0)
// The functions work on an SM_MAX_W-bit container. Callers size-cast their
// operands in and out, which makes them usable for any width up to SM_MAX_W-1.
package sm_pkg;

   localparam int   SM_MAX_W = 64;
   localparam logic SM_POS   = 1'b0;
   localparam logic SM_NEG   = 1'b1;

   function automatic logic [SM_MAX_W-1:0] max_mag(input int unsigned n);
      return (SM_MAX_W'(1) << n) - SM_MAX_W'(1);
   endfunction

   // A negative zero input maps onto plain 0, because -0 == 0 in two's complement.
   function automatic logic signed [SM_MAX_W-1:0] sm_to_tc(input logic sign,
                                                           input logic [SM_MAX_W-1:0] mag);
      logic signed [SM_MAX_W-1:0] v;
      v = $signed(mag);
      return (sign == SM_NEG) ? -v : v;
   endfunction

   // Returns the magnitude. The sign is set only for strictly negative values.
   function automatic logic [SM_MAX_W-1:0] tc_to_sm(input  logic signed [SM_MAX_W-1:0] v,
                                                    output logic sign);
      sign = (v < 0) ? SM_NEG : SM_POS;
      return (sign == SM_NEG) ? $unsigned(-v) : $unsigned(v);
   endfunction

endpackage

// File: rtl/sm_sat_add.sv
// sm_sat_add: combinational saturating signed adder.
//   a_i, b_i : TW-bit two's complement operands
//   sum_o    : a_i + b_i, clamped to +/-(2^LIM_W - 1)
// The sum is formed one bit wider than the operands, so the clamp compares
// against a result that cannot have wrapped.
module sm_sat_add
   import sm_pkg::*;
#(
   parameter int TW    = 10,
   parameter int LIM_W = 8
) (
   input  logic signed [TW-1:0] a_i,
   input  logic signed [TW-1:0] b_i,
   output logic signed [TW-1:0] sum_o
);

   localparam logic signed [TW:0] POS_LIM = (TW+1)'(max_mag(LIM_W));
   localparam logic signed [TW:0] NEG_LIM = -POS_LIM;

   logic signed [TW:0] full;

   always_comb begin
      full = (TW+1)'(a_i) + (TW+1)'(b_i);
      if (full > POS_LIM)
         sum_o = TW'(POS_LIM);
      else if (full < NEG_LIM)
         sum_o = TW'(NEG_LIM);
      else
         sum_o = TW'(full);
   end

endmodule

// File: rtl/sm_loop_filter.sv
// sm_loop_filter: sign-magnitude PI loop filter for the ADPLL.
//   clk, rst_n           : clock, async active-low reset
//   err_valid            : phase error sample present
//   err_sign, err_mag    : sign-magnitude phase error (W-bit magnitude)
//   clr                  : sync integrator clear + pipeline flush (beats err_valid)
//   out_valid            : one-cycle pulse, 2 cycles after an accepted sample
//   out_sign, out_mag    : registered sign-magnitude DCO word (held between samples)
//   sat                  : integrator sits at +/-(2^ACC_W - 1)
// Stage 1 updates the saturating integrator and captures the signed error.
// Stage 2 forms e*2^KP + sign(integ)*(|integ| >> KI) from the stage-1 registers.
// Those registers already include the sample now leaving stage 1.
module sm_loop_filter
   import sm_pkg::*;
#(
   parameter int W        = 5,
   parameter int ACC_W    = 8,
   parameter int KP_SHIFT = 1,
   parameter int KI_SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             err_valid,
   input  logic             err_sign,
   input  logic [W-1:0]     err_mag,
   input  logic             clr,
   output logic             out_valid,
   output logic             out_sign,
   output logic [ACC_W-1:0] out_mag,
   output logic             sat
);

   // Two headroom bits: one for the sign and one for the unclamped sum.
   localparam int TW = ACC_W + 2;
   localparam logic signed [TW-1:0] IMAX = TW'(max_mag(ACC_W));

   logic signed [TW-1:0] e_in, integ_sum, p_term, i_term, y_sum;
   logic signed [TW-1:0] integ_q, integ_d, e_q, e_d;
   logic [2:1]           vld_pipe_q, vld_pipe_d;
   logic                 sat_q, sat_d;
   logic                 out_sign_q, out_sign_d;
   logic [ACC_W-1:0]     out_mag_q, out_mag_d;
   logic [SM_MAX_W-1:0]  integ_mag;
   logic                 integ_neg;

   assign e_in = TW'(sm_to_tc(err_sign, SM_MAX_W'(err_mag)));

   sm_sat_add #(.TW(TW), .LIM_W(ACC_W)) u_int_add (
      .a_i   (integ_q),
      .b_i   (e_in),
      .sum_o (integ_sum)
   );

   // The integral term is shifted in magnitude, so it truncates toward zero.
   // This keeps the response symmetric for positive and negative integrator values.
   always_comb begin
      integ_mag = tc_to_sm(SM_MAX_W'(integ_q), integ_neg);
      i_term    = TW'(sm_to_tc(integ_neg, integ_mag >> KI_SHIFT));
      p_term    = e_q <<< KP_SHIFT;
   end

   sm_sat_add #(.TW(TW), .LIM_W(ACC_W)) u_out_add (
      .a_i   (p_term),
      .b_i   (i_term),
      .sum_o (y_sum)
   );

   always_comb begin
      integ_d    = integ_q;
      e_d        = e_q;
      sat_d      = sat_q;
      out_sign_d = out_sign_q;
      out_mag_d  = out_mag_q;
      // clr kills the incoming sample and also the one already in stage 1.
      vld_pipe_d[1] = err_valid & ~clr;
      vld_pipe_d[2] = vld_pipe_q[1] & ~clr;

      if (clr) begin
         integ_d = '0;
         sat_d   = 1'b0;
      end else if (err_valid) begin
         integ_d = integ_sum;
         e_d     = e_in;
         sat_d   = (integ_sum == IMAX) || (integ_sum == -IMAX);
      end

      if (vld_pipe_d[2])
         out_mag_d = ACC_W'(tc_to_sm(SM_MAX_W'(y_sum), out_sign_d));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         integ_q    <= '0;
         e_q        <= '0;
         vld_pipe_q <= '0;
         sat_q      <= 1'b0;
         out_sign_q <= 1'b0;
         out_mag_q  <= '0;
      end else begin
         integ_q    <= integ_d;
         e_q        <= e_d;
         vld_pipe_q <= vld_pipe_d;
         sat_q      <= sat_d;
         out_sign_q <= out_sign_d;
         out_mag_q  <= out_mag_d;
      end
   end

   assign out_valid = vld_pipe_q[2];
   assign out_sign  = out_sign_q;
   assign out_mag   = out_mag_q;
   assign sat       = sat_q;

endmodule
